// File: rtl/pcm_stream_pkg.sv
// Shared types and constants for the PCM-to-UART streaming stage.
// Sync header bytes, sample width and framing FSM states.
package pcm_stream_pkg;

    localparam int PCM_W = 16;
    localparam logic [7:0] SYNC0_BYTE = 8'hA5;
    localparam logic [7:0] SYNC1_BYTE = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        SYNC0,
        SYNC1,
        MSB,
        LSB
    } stream_state_t;

    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pcm_uart_streamer_tx.sv
// 8N1 byte serializer: start bit, d0..d7 LSB-first, stop bit.
// Each bit lasts BAUD_DIV clocks; ready returns once the stop bit has ended.
module uart_byte_tx
    import pcm_stream_pkg::*;
#(
    parameter int BAUD_DIV = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int DW = min1_clog2(BAUD_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(BAUD_DIV - 1);

    logic          act_q;
    logic [DW-1:0] div_q;
    logic [3:0]    bit_q;
    logic [9:0]    shr_q;
    logic          bit_end;

    assign bit_end = (div_q == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q <= 1'b0;
            div_q <= '0;
            bit_q <= '0;
            shr_q <= '1;
        end else if (load && !act_q) begin
            act_q <= 1'b1;
            div_q <= '0;
            bit_q <= '0;
            shr_q <= {1'b1, data, 1'b0};
        end else if (act_q) begin
            if (bit_end) begin
                div_q <= '0;
                shr_q <= {1'b1, shr_q[9:1]};
                bit_q <= bit_q + 4'd1;
                if (bit_q == 4'd9) begin
                    act_q <= 1'b0;
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    // Line is forced high whenever no frame is in flight, so reset idles it at once.
    assign tx    = ~act_q | shr_q[0];
    assign ready = ~act_q;

endmodule

// File: rtl/pcm_uart_streamer.sv
// Captures PCM samples on pcm_clk rising edges into a FIFO and streams
// them as framed UART bytes: A5 5A header, then MSB/LSB per sample.
module pcm_uart_streamer
    import pcm_stream_pkg::*;
#(
    parameter int BAUD_DIV  = 3,
    parameter int FIFO_AW   = 4,
    parameter int FRAME_LEN = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pcm_clk,
    input  logic [PCM_W-1:0] pcm_in,
    output logic             uart_tx,
    output logic             busy,
    output logic             overflow,
    output logic [FIFO_AW:0] fifo_level
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int FC_W  = min1_clog2(FRAME_LEN);
    localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAME_LEN - 1);

    logic             s1_q, s2_q, s3_q;
    logic             pcm_edge;
    logic             push_q;
    logic [PCM_W-1:0] smp_q;

    logic [PCM_W-1:0] mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q;
    logic             ovf_q;
    logic             fifo_full, fifo_empty;
    logic             push_ok;
    logic [PCM_W-1:0] head;

    stream_state_t    state_q, state_d;
    logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]       hold_lsb_q;
    logic             pop;
    logic             tx_load;
    logic [7:0]       tx_data;
    logic             tx_ready;

    assign pcm_edge = s2_q & ~s3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            push_q <= 1'b0;
            smp_q  <= '0;
        end else begin
            s1_q   <= pcm_clk;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            push_q <= pcm_edge;
            if (pcm_edge) begin
                smp_q <= pcm_in;
            end
        end
    end

    assign fifo_full  = (cnt_q == FULL_LVL);
    assign fifo_empty = (cnt_q == '0);
    // A full FIFO still takes the write when the same cycle frees a slot.
    assign push_ok    = push_q & (~fifo_full | pop);
    assign head       = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= smp_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push_ok) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (push_q && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            hold_lsb_q  <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            if (pop) begin
                hold_lsb_q <= head[7:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        pop         = 1'b0;
        tx_load     = 1'b0;
        tx_data     = 8'h00;
        if (tx_ready) begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        tx_load = 1'b1;
                        if (frame_cnt_q == '0) begin
                            tx_data = SYNC0_BYTE;
                            state_d = SYNC0;
                        end else begin
                            pop     = 1'b1;
                            tx_data = head[15:8];
                            state_d = MSB;
                        end
                    end
                end
                SYNC0: begin
                    tx_load = 1'b1;
                    tx_data = SYNC1_BYTE;
                    state_d = SYNC1;
                end
                SYNC1: begin
                    pop     = 1'b1;
                    tx_load = 1'b1;
                    tx_data = head[15:8];
                    state_d = MSB;
                end
                MSB: begin
                    tx_load = 1'b1;
                    tx_data = hold_lsb_q;
                    state_d = LSB;
                end
                LSB: begin
                    frame_cnt_d = (frame_cnt_q == FC_LAST) ?
                                  '0 : frame_cnt_q + 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    uart_byte_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .load (tx_load),
        .data (tx_data),
        .tx   (uart_tx),
        .ready(tx_ready)
    );

    assign busy       = (state_q != IDLE) | ~fifo_empty;
    assign overflow   = ovf_q;
    assign fifo_level = cnt_q;

endmodule

// File: tb/tb_pcm_uart_streamer.sv
// Bench for pcm_uart_streamer: byte-level stream model plus directed
// literal checks of latency, framing, overflow, reset and held pcm_clk.
module tb_pcm_uart_streamer;

    localparam int B     = 3;
    localparam int AW    = 2;
    localparam int FL    = 4;
    localparam int DEPTH = 4;
    localparam int MID   = B / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pcm_clk = 1'b0;
    logic [15:0]   pcm_in = 16'h0;
    logic          uart_tx;
    logic          busy;
    logic          overflow;
    logic [AW:0]   fifo_level;

    int total = 0;
    int bad   = 0;

    pcm_uart_streamer #(
        .BAUD_DIV (B),
        .FIFO_AW  (AW),
        .FRAME_LEN(FL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pcm_clk   (pcm_clk),
        .pcm_in    (pcm_in),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .overflow  (overflow),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         msb;
    } eb_t;

    typedef struct {
        int          due;
        logic [15:0] v;
    } wr_t;

    function automatic eb_t mk_eb(input logic [7:0] b, input bit m);
        eb_t r;
        r.b   = b;
        r.msb = m;
        return r;
    endfunction

    function automatic wr_t mk_wr(input int d, input logic [15:0] v);
        wr_t r;
        r.due = d;
        r.v   = v;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model state: samples in flight, expected byte stream, occupancy.
    int          ncyc = 0;
    logic        pc_prev = 1'b0;
    wr_t         pend[$];
    eb_t         expq[$];
    int          m_lvl = 0;
    int          m_acc = 0;
    bit          m_ovf = 1'b0;
    bit          d_act = 1'b0;
    int          d_cnt = 0;
    logic [7:0]  d_byte = 8'h0;
    eb_t         d_exp;
    logic [7:0]  log_q[$];
    int          start_at[$];
    int          rise_at[$];
    int          peak = 0;

    always @(negedge clk) begin : cmp
        bit  pop_now;
        bit  acc;
        int  i;
        wr_t w;
        ncyc++;
        pop_now = 1'b0;
        if (rst) begin
            chk("rst_tx", uart_tx, 1);
            chk("rst_busy", busy, 0);
            chk("rst_ovf", overflow, 0);
            chk("rst_lvl", fifo_level, 0);
            pend.delete();
            expq.delete();
            m_lvl   = 0;
            m_acc   = 0;
            m_ovf   = 1'b0;
            d_act   = 1'b0;
            pc_prev = 1'b0;
        end else begin
            if (!d_act) begin
                if (uart_tx == 1'b0) begin
                    d_act  = 1'b1;
                    d_cnt  = 0;
                    d_byte = 8'h0;
                    start_at.push_back(ncyc);
                    chk("byte_expected", expq.size() > 0, 1);
                    if (expq.size() > 0) begin
                        d_exp   = expq.pop_front();
                        pop_now = d_exp.msb;
                    end else begin
                        d_exp = mk_eb(8'h00, 1'b0);
                    end
                end
            end else begin
                d_cnt++;
                if (d_cnt >= MID && ((d_cnt - MID) % B) == 0) begin
                    i = (d_cnt - MID) / B;
                    if (i == 0) begin
                        chk("start_bit", uart_tx, 0);
                    end else if (i <= 8) begin
                        d_byte[i-1] = uart_tx;
                    end else begin
                        chk("stop_bit", uart_tx, 1);
                        chk("stream_byte", d_byte, d_exp.b);
                        log_q.push_back(d_byte);
                        d_act = 1'b0;
                    end
                end
            end
            if (pend.size() > 0 && pend[0].due == ncyc) begin
                w   = pend.pop_front();
                acc = (m_lvl < DEPTH) || pop_now;
                if (acc) begin
                    if (m_acc % FL == 0) begin
                        expq.push_back(mk_eb(8'hA5, 1'b0));
                        expq.push_back(mk_eb(8'h5A, 1'b0));
                    end
                    expq.push_back(mk_eb(w.v[15:8], 1'b1));
                    expq.push_back(mk_eb(w.v[7:0], 1'b0));
                    m_acc++;
                    m_lvl++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (pop_now) begin
                m_lvl--;
            end
            chk("fifo_level", fifo_level, m_lvl);
            chk("overflow", overflow, m_ovf);
            if (m_lvl > 0 || d_act) begin
                chk("busy_when_work", busy, 1);
            end
            if (int'(fifo_level) > peak) begin
                peak = fifo_level;
            end
            // pcm_clk seen here is what the DUT samples at the next edge.
            if (pcm_clk && !pc_prev) begin
                pend.push_back(mk_wr(ncyc + 4, pcm_in));
                rise_at.push_back(ncyc);
            end
            pc_prev = pcm_clk;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        pcm_clk = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic pulse(input logic [15:0] v, input int hi, input int lo);
        pcm_in  = v;
        pcm_clk = 1'b1;
        cyc(hi);
        pcm_clk = 1'b0;
        cyc(lo);
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        int k;
        k = 0;
        while ((busy || d_act || pend.size() > 0 || expq.size() > 0)
               && k < maxc) begin
            cyc(1);
            k++;
        end
        chk({nm, "_drained"}, k < maxc, 1);
        chk({nm, "_busy0"}, busy, 0);
        chk({nm, "_tx_idle"}, uart_tx, 1);
    endtask

    task automatic chk_log(input string nm, input logic [7:0] e[$]);
        int a;
        chk({nm, "_len"}, log_q.size(), e.size());
        foreach (e[i]) begin
            a = (i < log_q.size()) ? int'(log_q[i]) : -1;
            chk($sformatf("%s_b%0d", nm, i), a, e[i]);
        end
    endtask

    task automatic clr();
        log_q.delete();
        start_at.delete();
        rise_at.delete();
        peak = 0;
    endtask

    logic [7:0] ex[$];

    initial begin
        #1;
        rst = 1'b1;
        cyc(3);
        chk("init_tx", uart_tx, 1);
        chk("init_busy", busy, 0);
        chk("init_ovf", overflow, 0);
        chk("init_lvl", fifo_level, 0);
        rst = 1'b0;
        cyc(2);

        clr();
        pulse(16'h1234, 4, 4);
        wait_idle("t1", 400);
        ex = '{8'hA5, 8'h5A, 8'h12, 8'h34};
        chk_log("t1", ex);
        chk("t1_latency",
            (start_at.size() > 0 && rise_at.size() > 0) ?
            start_at[0] - rise_at[0] : -1, 5);
        chk("t1_peak", peak, 1);
        chk("t1_lvl0", fifo_level, 0);

        do_reset();
        clr();
        for (int i = 1; i <= 5; i++) begin
            pulse(16'(i), 4, 196);
        end
        wait_idle("t2", 400);
        ex = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03,
               8'h00, 8'h04, 8'hA5, 8'h5A, 8'h00, 8'h05};
        chk_log("t2", ex);

        do_reset();
        clr();
        for (int i = 1; i <= 7; i++) begin
            pulse({8'(i), 8'(i)}, 4, 4);
            if (i == 4) begin
                chk("t3_lvl4", fifo_level, 4);
                chk("t3_ovf_before", overflow, 0);
            end
            if (i == 5) begin
                chk("t3_ovf_after5", overflow, 1);
            end
        end
        wait_idle("t3", 600);
        ex = '{8'hA5, 8'h5A, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03,
               8'h04, 8'h04};
        chk_log("t3", ex);
        chk("t3_peak", peak, 4);
        chk("t3_ovf_sticky", overflow, 1);
        do_reset();
        chk("t3_ovf_rst", overflow, 0);

        clr();
        pulse(16'h1111, 4, 4);
        pulse(16'h2222, 4, 4);
        pulse(16'h3333, 4, 4);
        pulse(16'h4444, 4, 4);
        cyc(31);
        pulse(16'h5555, 4, 4);
        chk("t4_lvl4", fifo_level, 4);
        chk("t4_ovf0", overflow, 0);
        wait_idle("t4", 800);
        ex = '{8'hA5, 8'h5A, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33,
               8'h44, 8'h44, 8'hA5, 8'h5A, 8'h55, 8'h55};
        chk_log("t4", ex);
        chk("t4_ovf_end", overflow, 0);

        do_reset();
        clr();
        pulse(16'h1234, 4, 4);
        cyc(66);
        rst = 1'b1;
        #1;
        chk("t5_tx", uart_tx, 1);
        chk("t5_busy", busy, 0);
        chk("t5_lvl", fifo_level, 0);
        cyc(2);
        rst = 1'b0;
        cyc(4);
        pulse(16'h0BCD, 4, 4);
        wait_idle("t5", 400);
        ex = '{8'hA5, 8'h5A, 8'hA5, 8'h5A, 8'h0B, 8'hCD};
        chk_log("t5", ex);

        do_reset();
        clr();
        pulse(16'h7FFF, 500, 10);
        pulse(16'h8000, 200, 10);
        wait_idle("t6", 400);
        ex = '{8'hA5, 8'h5A, 8'h7F, 8'hFF, 8'h80, 8'h00};
        chk_log("t6", ex);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
